// File: rtl/cubic_poly_pkg.sv
// Shared types for the cubic evaluator scheduler: FSM states, result width, stage-1 record.
package cubic_poly_pkg;

    localparam int RES_W    = 12;
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic [3:0]          x;
        logic [3:0]          k;
        logic [7:0]          partial;
    } stage_t;

endpackage

// File: rtl/cubic_rr_arb.sv
// Round-robin arbiter: one-hot grant starting after the last winner; pointer moves only on a grant.
module cubic_rr_arb
    import cubic_poly_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && en && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Every grant is an accept (grant implies req), so the pointer follows the grant directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cubic_poly_sched.sv
// Shares a two-stage x*x*x + k evaluator among NUM_REQ requesters with flush/drain control.
// Optional per-requester grant counters are built only when CUBIC_SCHED_STATS_EN is defined.
module cubic_poly_sched
    import cubic_poly_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0][3:0]   req_x,
    input  logic [NUM_REQ-1:0][3:0]   req_k,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_data,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [NUM_REQ-1:0][15:0]  stat_grant_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic [RES_W-1:0] cube_finish(input logic [7:0] sq,
                                                     input logic [3:0] x,
                                                     input logic [3:0] k);
        return RES_W'(sq) * RES_W'(x) + RES_W'(k);
    endfunction

    fsm_state_t          state;
    stage_t              stg_p1;
    logic                vld_p2;
    logic [ID_W-1:0]     id_p2;
    logic [RES_W-1:0]    data_p2;

    logic                stall;
    logic                empty;
    logic                grant_en;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [3:0]          x_sel;
    logic [3:0]          k_sel;

    assign stall    = vld_p2 & ~rsp_ready;
    assign empty    = ~stg_p1.valid & ~vld_p2;
    assign grant_en = rst_n && (state == ST_RUN) && !flush_req && !stall;
    assign x_sel    = req_x[grant_idx];
    assign k_sel    = req_k[grant_idx];

    cubic_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stage 1: square of the granted x, carried with x, k and requester id
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_p1 <= '0;
        end else if (!stall) begin
            stg_p1.valid <= |grant;
            if (|grant) begin
                stg_p1.id      <= MAX_ID_W'(grant_idx);
                stg_p1.x       <= x_sel;
                stg_p1.k       <= k_sel;
                stg_p1.partial <= {4'b0, x_sel} * {4'b0, x_sel};
            end
        end
    end

    // Stage 2: finished result; this register is the response port and holds while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            id_p2   <= '0;
            data_p2 <= '0;
        end else if (!stall) begin
            vld_p2 <= stg_p1.valid;
            if (stg_p1.valid) begin
                id_p2   <= stg_p1.id[ID_W-1:0];
                data_p2 <= cube_finish(stg_p1.partial, stg_p1.x, stg_p1.k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (flush_req) state <= ST_DRAIN;
                ST_DRAIN: if (empty)     state <= ST_DONE;
                ST_DONE:  if (!flush_req) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign req_ready  = grant;
    assign rsp_valid  = vld_p2;
    assign rsp_id     = id_p2;
    assign rsp_data   = data_p2;
    assign flush_done = rst_n && (state == ST_DRAIN) && empty;

    // Upper id bits are unused when ID_W is narrower than the stage record field.
    logic unused_id_bits;
    assign unused_id_bits = ^stg_p1.id;

`ifdef CUBIC_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_REQ-1:0][15:0] grant_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
            end
        end
    end

    assign stat_grant_cnt = grant_cnt;
`else
    assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_cubic_poly_sched.sv
// Directed bench for cubic_poly_sched: vector table plus hand-built stall, flush and reset sequences.
module tb_cubic_poly_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0][3:0]  req_x;
    logic [N-1:0][3:0]  req_k;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [11:0]        rsp_data;
    logic               flush_req;
    logic               flush_done;
    logic [N-1:0][15:0] stat_grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cubic_poly_sched #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_x          (req_x),
        .req_k          (req_k),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .stat_grant_cnt (stat_grant_cnt)
    );

    typedef struct {
        int         id;
        logic [3:0] x;
        logic [3:0] k;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        flush_req = 1'b0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vt[0] = '{id: 2, x: 4'd3,  k: 4'd5,  exp_data: 12'd32};
        vt[1] = '{id: 0, x: 4'd0,  k: 4'd0,  exp_data: 12'd0};
        vt[2] = '{id: 3, x: 4'd15, k: 4'd15, exp_data: 12'd3390};
        vt[3] = '{id: 1, x: 4'd1,  k: 4'd7,  exp_data: 12'd8};
        vt[4] = '{id: 0, x: 4'd2,  k: 4'd9,  exp_data: 12'd17};
        vt[5] = '{id: 3, x: 4'd10, k: 4'd1,  exp_data: 12'd1001};
        vt[6] = '{id: 1, x: 4'd7,  k: 4'd4,  exp_data: 12'd347};

        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_k     = '0;
        rsp_ready = 1'b1;
        flush_req = 1'b0;

        // Reset state with every requester asking
        tick();
        req_valid = '1;
        tick();
        settle();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_flush_done", 32'(flush_done), 32'd0);
        chk("reset_stat", 32'(stat_grant_cnt == '0), 32'd1);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single-request vectors: grant, 2-cycle latency, result and id
        for (int i = 0; i < 7; i++) begin
            req_valid = '0;
            req_x[vt[i].id] = vt[i].x;
            req_k[vt[i].id] = vt[i].k;
            req_valid[vt[i].id] = 1'b1;
            settle();
            chk("vec_grant", 32'(req_ready), 32'd1 << vt[i].id);
            tick();
            req_valid = '0;
            settle();
            chk("vec_lat1_valid", 32'(rsp_valid), 32'd0);
            tick();
            settle();
            chk("vec_valid", 32'(rsp_valid), 32'd1);
            chk("vec_data", 32'(rsp_data), 32'(vt[i].exp_data));
            chk("vec_id", 32'(rsp_id), 32'(vt[i].id));
            tick();
            settle();
            chk("vec_after_valid", 32'(rsp_valid), 32'd0);
            tick();
        end

        // Round robin from index 0 with all requesters continuously valid
        reset_dut();
        req_x = {N{4'd15}};
        req_k = {N{4'd15}};
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5) ? '1 : '0;
            settle();
            chk("rr_grant", 32'(req_ready), (c < 5) ? (32'd1 << (c % 4)) : 32'd0);
            if (c >= 2) begin
                chk("rr_valid", 32'(rsp_valid), 32'd1);
                chk("rr_data", 32'(rsp_data), 32'd3390);
                chk("rr_id", 32'(rsp_id), 32'((c - 2) % 4));
            end
            tick();
        end
        settle();
        chk("rr_tail_valid", 32'(rsp_valid), 32'd0);
        tick();

        // Back-pressure: two results in flight, sink stalls for 5 cycles
        req_valid = 4'b0001;
        req_x[0] = 4'd2;
        req_k[0] = 4'd1;
        settle();
        chk("stall_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 4'b0010;
        req_x[1] = 4'd3;
        req_k[1] = 4'd0;
        settle();
        chk("stall_grant1", 32'(req_ready), 32'd2);
        tick();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b0100;
            rsp_ready = 1'b0;
            settle();
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'd9);
            chk("stall_id", 32'(rsp_id), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        settle();
        chk("unstall_first_data", 32'(rsp_data), 32'd9);
        chk("unstall_first_valid", 32'(rsp_valid), 32'd1);
        tick();
        settle();
        chk("unstall_second_valid", 32'(rsp_valid), 32'd1);
        chk("unstall_second_data", 32'(rsp_data), 32'd27);
        chk("unstall_second_id", 32'(rsp_id), 32'd1);
        tick();
        settle();
        chk("unstall_tail_valid", 32'(rsp_valid), 32'd0);
        tick();

        // Flush with two results in flight
        req_valid = 4'b0001;
        req_x[0] = 4'd1;
        req_k[0] = 4'd0;
        settle();
        chk("flush_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 4'b0010;
        req_x[1] = 4'd2;
        req_k[1] = 4'd0;
        settle();
        chk("flush_grant1", 32'(req_ready), 32'd2);
        tick();
        req_valid = 4'b0100;
        flush_req = 1'b1;
        settle();
        chk("flush_same_cycle_ready", 32'(req_ready), 32'd0);
        chk("flush_rsp0_data", 32'(rsp_data), 32'd1);
        chk("flush_done_early0", 32'(flush_done), 32'd0);
        tick();
        settle();
        chk("drain_ready", 32'(req_ready), 32'd0);
        chk("flush_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("flush_rsp1_data", 32'(rsp_data), 32'd8);
        chk("flush_done_early1", 32'(flush_done), 32'd0);
        tick();
        settle();
        chk("flush_drained_valid", 32'(rsp_valid), 32'd0);
        chk("flush_done_pulse", 32'(flush_done), 32'd1);
        chk("flush_pulse_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        chk("flush_done_single", 32'(flush_done), 32'd0);
        chk("done_hold_ready", 32'(req_ready), 32'd0);
        tick();
        flush_req = 1'b0;
        settle();
        chk("done_exit_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        chk("run_again_grant", 32'(req_ready), 32'd4);
        tick();
        req_valid = '0;
        tick();
        settle();
        chk("run_again_valid", 32'(rsp_valid), 32'd1);
        chk("run_again_id", 32'(rsp_id), 32'd2);
        chk("run_again_data", 32'(rsp_data), 32'd3390);
        tick();

        // Flush with an empty pipeline
        flush_req = 1'b1;
        settle();
        chk("eflush_done0", 32'(flush_done), 32'd0);
        tick();
        settle();
        chk("eflush_done1", 32'(flush_done), 32'd1);
        tick();
        flush_req = 1'b0;
        settle();
        chk("eflush_done2", 32'(flush_done), 32'd0);
        tick();
        req_valid = 4'b0001;
        settle();
        chk("eflush_run_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        tick();
        settle();
        chk("eflush_rsp_data", 32'(rsp_data), 32'd1);
        tick();

        // Reset while stage 1 holds a request
        req_valid = 4'b0010;
        settle();
        chk("rst_mid_grant", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        req_valid = '1;
        settle();
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_data", 32'(rsp_data), 32'd0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        req_valid = '1;
        settle();
        chk("rst_mid_ptr0", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        tick();
        tick();

`ifdef CUBIC_SCHED_STATS_EN
        reset_dut();
        req_valid = 4'b0010;
        repeat (70000) tick();
        req_valid = '0;
        settle();
        chk("stat_sat_req1", 32'(stat_grant_cnt[1]), 32'hFFFF);
        chk("stat_req0", 32'(stat_grant_cnt[0]), 32'd0);
        tick();
`else
        settle();
        chk("stat_tied_zero", 32'(stat_grant_cnt == '0), 32'd1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
